spi_burst_engine: RTL and testbench

- Multi-byte transfer sequencer that sits directly upstream of spi_master and drives spi_master's MMIO slave port as a bus master.
- Moves N bytes between a CPU-side TX byte FIFO and RX byte FIFO, one 8-bit SPI transfer at a time, so firmware does not poll per byte.
- Typical use: SD-card block reads (fill 0xFF, capture 512 bytes) and command/data writes (pop TX, discard RX).

---
 rtl/spi_burst_engine_pkg.sv | 23 ++
 rtl/spi_burst_engine_if.sv | 20 ++
 rtl/spi_burst_engine_byte_fifo.sv | 54 +++++
 rtl/spi_burst_engine.sv | 212 +++++++++++++++++++++
 tb/tb_spi_burst_engine.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_burst_engine_pkg.sv
// Shared definitions for the SPI burst engine: spi_master register map,
// STATUS bit positions and the sequencer state encoding.
package spi_burst_engine_pkg;

    localparam logic [31:0] RegCtrl   = 32'h0;
    localparam logic [31:0] RegData   = 32'h4;
    localparam logic [31:0] RegStatus = 32'h8;
    localparam logic [31:0] RegCs     = 32'hC;

    localparam int unsigned StatusBusy = 0;
    localparam int unsigned StatusDone = 1;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWrData,
        StGap,
        StPoll,
        StRdData,
        StPush
    } state_e;

endpackage

// File: rtl/spi_burst_engine_if.sv
// Simple valid/ready MMIO bus between the burst engine (master) and spi_master (slave).
interface spi_burst_engine_if;
    logic        m_valid;
    logic        m_write;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata;
    logic        m_ready;

    modport master (
        output m_valid, m_write, m_addr, m_wdata, m_wstrb,
        input  m_rdata, m_ready
    );

    modport slave (
        input  m_valid, m_write, m_addr, m_wdata, m_wstrb,
        output m_rdata, m_ready
    );
endinterface

// File: rtl/spi_burst_engine_byte_fifo.sv
// First-word-fall-through byte FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle, a pop from an empty FIFO is ignored.
module spi_burst_engine_byte_fifo #(
    parameter int unsigned Depth = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [7:0]             wdata_i,
    input  logic                   pop_i,
    output logic [7:0]             rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] level_o
);
    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned LW = AW + 1;
    localparam logic [AW:0] FullLevel = LW'(Depth);

    logic [7:0]    mem_q [Depth];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == FullLevel);
    assign level_o = level_q;
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    // Gate the head so the output is a defined zero while empty.
    assign rdata_o = empty_o ? 8'h00 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        level_d  = level_q + LW'(do_push) - LW'(do_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/spi_burst_engine.sv
// Burst sequencer: moves cmd_len bytes between the TX/RX FIFOs and spi_master by
// writing DATA, polling STATUS and reading DATA back once per byte.
module spi_burst_engine
    import spi_burst_engine_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] SPI_BASE   = 32'h8000_0050,
    parameter logic [7:0]  FILL_BYTE  = 8'hFF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_start,
    input  logic [15:0]                 cmd_len,
    input  logic                        cmd_tx_fill,
    input  logic                        cmd_rx_discard,
    input  logic                        cmd_abort,
    output logic                        eng_busy,
    output logic                        eng_done,
    output logic                        eng_aborted,
    output logic [15:0]                 eng_count,
    input  logic                        tx_wvalid,
    input  logic [7:0]                  tx_wdata,
    output logic                        tx_wready,
    output logic                        rx_rvalid,
    output logic [7:0]                  rx_rdata,
    input  logic                        rx_rready,
    output logic [$clog2(FIFO_DEPTH):0] tx_level,
    output logic [$clog2(FIFO_DEPTH):0] rx_level,
    spi_burst_engine_if.master          bus
);
    state_e      state_q, state_d;
    logic [15:0] rem_q, rem_d, count_q, count_d;
    logic        fill_q, fill_d, discard_q, discard_d, abort_q, abort_d;
    logic        busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic [1:0]  gap_q, gap_d;
    logic        m_valid_q, m_valid_d, m_write_q, m_write_d;
    logic [31:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
    logic [3:0]  m_wstrb_q, m_wstrb_d;

    logic       tx_pop, rx_push, tx_empty, tx_full, rx_empty, rx_full;
    logic [7:0] tx_rdata, tx_byte;
    logic       ack, abort_now, fetch_ok, status_ready, unused_rdata;

    assign ack          = m_valid_q & bus.m_ready;
    assign abort_now    = abort_q | cmd_abort;
    // RX space is reserved here, so the later push can never overflow.
    assign fetch_ok     = (fill_q | ~tx_empty) & (discard_q | ~rx_full);
    assign status_ready = ~bus.m_rdata[StatusBusy] & bus.m_rdata[StatusDone];
    assign tx_byte      = fill_q ? FILL_BYTE : tx_rdata;
    assign unused_rdata = ^bus.m_rdata[31:8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            count_q   <= '0;
            fill_q    <= 1'b0;
            discard_q <= 1'b0;
            abort_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            rx_byte_q <= '0;
            gap_q     <= '0;
            m_valid_q <= 1'b0;
            m_write_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wstrb_q <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            count_q   <= count_d;
            fill_q    <= fill_d;
            discard_q <= discard_d;
            abort_q   <= abort_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            rx_byte_q <= rx_byte_d;
            gap_q     <= gap_d;
            m_valid_q <= m_valid_d;
            m_write_q <= m_write_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_wstrb_q <= m_wstrb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cmd_start && cmd_len != 16'd0) state_d = StFetch;
            StFetch:  if (abort_now) state_d = StIdle;
                      else if (fetch_ok) state_d = StWrData;
            StWrData: if (ack) state_d = StGap;
            StGap:    if (gap_q == 2'd1) state_d = StPoll;
            StPoll:   if (ack && status_ready) state_d = StRdData;
            StRdData: if (ack) state_d = StPush;
            StPush:   state_d = (rem_q == 16'd1) ? StIdle : StFetch;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        rem_d     = rem_q;
        count_d   = count_q;
        fill_d    = fill_q;
        discard_d = discard_q;
        abort_d   = abort_q | (cmd_abort & busy_q);
        busy_d    = busy_q;
        done_d    = 1'b0;
        aborted_d = aborted_q;
        rx_byte_d = rx_byte_q;
        gap_d     = gap_q;
        m_valid_d = m_valid_q;
        m_write_d = m_write_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_wstrb_d = m_wstrb_q;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        unique case (state_q)
            StIdle: if (cmd_start) begin
                fill_d    = cmd_tx_fill;
                discard_d = cmd_rx_discard;
                rem_d     = cmd_len;
                count_d   = '0;
                aborted_d = 1'b0;
                abort_d   = 1'b0;
                if (cmd_len == 16'd0) done_d = 1'b1;
                else                  busy_d = 1'b1;
            end
            StFetch: if (abort_now) begin
                done_d    = 1'b1;
                aborted_d = 1'b1;
                busy_d    = 1'b0;
                abort_d   = 1'b0;
            end else if (fetch_ok) begin
                tx_pop    = ~fill_q;
                m_valid_d = 1'b1;
                m_write_d = 1'b1;
                m_addr_d  = SPI_BASE + RegData;
                m_wdata_d = {24'h0, tx_byte};
                m_wstrb_d = 4'b0001;
            end
            StWrData: if (ack) begin
                m_valid_d = 1'b0;
                gap_d     = 2'd0;
            end
            StGap: gap_d = gap_q + 2'd1;
            // A low m_valid here is the mandatory idle cycle before the next read.
            StPoll, StRdData: if (!m_valid_q) begin
                m_valid_d = 1'b1;
                m_write_d = 1'b0;
                m_addr_d  = SPI_BASE + ((state_q == StPoll) ? RegStatus : RegData);
                m_wdata_d = '0;
                m_wstrb_d = 4'b0000;
            end else if (ack) begin
                m_valid_d = 1'b0;
                if (state_q == StRdData) rx_byte_d = bus.m_rdata[7:0];
            end
            StPush: begin
                rx_push = ~discard_q;
                if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
                rem_d = rem_q - 16'd1;
                if (rem_q == 16'd1) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    spi_burst_engine_byte_fifo #(.Depth(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (tx_wvalid),
        .wdata_i (tx_wdata),
        .pop_i   (tx_pop),
        .rdata_o (tx_rdata),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .level_o (tx_level)
    );

    spi_burst_engine_byte_fifo #(.Depth(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rx_push),
        .wdata_i (rx_byte_q),
        .pop_i   (rx_rready),
        .rdata_o (rx_rdata),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .level_o (rx_level)
    );

    assign tx_wready   = ~tx_full;
    assign rx_rvalid   = ~rx_empty;
    assign eng_busy    = busy_q;
    assign eng_done    = done_q;
    assign eng_aborted = aborted_q;
    assign eng_count   = count_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_write = m_write_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_wstrb = m_wstrb_q;
endmodule

// File: tb/tb_spi_burst_engine.sv
// Bench for spi_burst_engine: loopback spi_master model (DATA read returns ~last write)
// plus a queue-based reference of which bytes get written and received.
module tb_spi_burst_engine;
    localparam logic [31:0] DataAddr   = 32'h8000_0054;
    localparam logic [31:0] StatusAddr = 32'h8000_0058;

    logic        clk, reset;
    logic        cmd_start, cmd_tx_fill, cmd_rx_discard, cmd_abort;
    logic [15:0] cmd_len;
    logic        eng_busy, eng_done, eng_aborted;
    logic [15:0] eng_count;
    logic        tx_wvalid, tx_wready, rx_rvalid, rx_rready;
    logic [7:0]  tx_wdata, rx_rdata;
    logic [4:0]  tx_level, rx_level;

    spi_burst_engine_if bus ();

    spi_burst_engine dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_start      (cmd_start),
        .cmd_len        (cmd_len),
        .cmd_tx_fill    (cmd_tx_fill),
        .cmd_rx_discard (cmd_rx_discard),
        .cmd_abort      (cmd_abort),
        .eng_busy       (eng_busy),
        .eng_done       (eng_done),
        .eng_aborted    (eng_aborted),
        .eng_count      (eng_count),
        .tx_wvalid      (tx_wvalid),
        .tx_wdata       (tx_wdata),
        .tx_wready      (tx_wready),
        .rx_rvalid      (rx_rvalid),
        .rx_rdata       (rx_rdata),
        .rx_rready      (rx_rready),
        .tx_level       (tx_level),
        .rx_level       (rx_level),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0, ack_cnt = 0, hold_viol = 0, gap_viol = 0, bad_req = 0;
    int run_len = 0, max_run = 0;
    int wr_hold = 0, xfer_cycles = 3;
    logic [31:0] wr_log[$];
    logic [7:0]  rx_log[$];
    logic [7:0]  tx_model[$];
    logic [31:0] exp_wr[$];
    logic [7:0]  exp_rx[$];

    // spi_master stand-in: one-cycle ready, busy for xfer_cycles after a DATA write.
    int         sl_busy, hold_cnt;
    bit         sl_done;
    logic [7:0] sl_shift;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.m_ready <= 1'b0;
            bus.m_rdata <= '0;
            sl_busy = 0; sl_done = 0; hold_cnt = 0; sl_shift = 8'h00;
        end else begin
            bus.m_ready <= 1'b0;
            if (sl_busy > 0) begin
                sl_busy--;
                if (sl_busy == 0) sl_done = 1;
            end
            if (bus.m_valid && !bus.m_ready) begin
                if (bus.m_write && bus.m_addr == DataAddr && bus.m_wstrb == 4'b0001) begin
                    if (hold_cnt < wr_hold) hold_cnt++;
                    else begin
                        hold_cnt = 0;
                        bus.m_ready <= 1'b1;
                        wr_log.push_back(bus.m_wdata);
                        sl_shift = bus.m_wdata[7:0];
                        sl_busy = xfer_cycles;
                        sl_done = 0;
                    end
                end else if (!bus.m_write && bus.m_addr == StatusAddr && bus.m_wstrb == 4'b0) begin
                    bus.m_ready <= 1'b1;
                    bus.m_rdata <= {30'h0, sl_done, sl_busy != 0};
                end else if (!bus.m_write && bus.m_addr == DataAddr && bus.m_wstrb == 4'b0) begin
                    bus.m_ready <= 1'b1;
                    bus.m_rdata <= {24'h0, ~sl_shift};
                end else begin
                    bus.m_ready <= 1'b1;
                    bad_req++;
                end
            end
        end
    end

    // Protocol and output monitor.
    logic        pv, pr, pw;
    logic [31:0] pa, pd;
    always @(negedge clk) begin
        if (reset) begin
            pv = 0; pr = 0; run_len = 0;
        end else begin
            if (eng_done) done_cnt++;
            if (rx_rvalid && rx_rready) rx_log.push_back(rx_rdata);
            if (bus.m_valid && bus.m_ready) ack_cnt++;
            if (bus.m_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else run_len = 0;
            if (pv && !pr && (!bus.m_valid || bus.m_addr != pa || bus.m_wdata != pd ||
                              bus.m_write != pw)) hold_viol++;
            if (pv && pr && bus.m_valid) gap_viol++;
            pv = bus.m_valid; pr = bus.m_ready; pw = bus.m_write;
            pa = bus.m_addr;  pd = bus.m_wdata;
        end
    end

    // Reference: byte i of a burst is FILL or the next TX entry; RX gets its complement.
    function automatic void plan_burst(input int len, input bit fill, input bit discard);
        logic [7:0] b;
        exp_wr.delete();
        exp_rx.delete();
        for (int i = 0; i < len; i++) begin
            b = fill ? 8'hFF : tx_model.pop_front();
            exp_wr.push_back({24'h0, b});
            if (!discard) exp_rx.push_back(~b);
        end
    endfunction

    task automatic push_tx(input logic [7:0] b);
        @(posedge clk); #1;
        tx_wvalid = 1'b1; tx_wdata = b;
        @(posedge clk); #1;
        tx_wvalid = 1'b0;
        tx_model.push_back(b);
    endtask

    task automatic pop_rx(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rx_rready = 1'b1;
            @(posedge clk); #1;
            rx_rready = 1'b0;
        end
    endtask

    task automatic start(input logic [15:0] len, input logic fill, input logic discard);
        @(posedge clk); #1;
        cmd_start = 1'b1; cmd_len = len; cmd_tx_fill = fill; cmd_rx_discard = discard;
        @(posedge clk); #1;
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n = 0;
        while (!eng_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = eng_done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_start = 0; cmd_len = 0; cmd_tx_fill = 0; cmd_rx_discard = 0; cmd_abort = 0;
        tx_wvalid = 0; tx_wdata = 0; rx_rready = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({eng_busy, eng_done, eng_aborted, eng_count} !== 19'd0) begin
            failures++;
            $display("FAIL reset_eng got %b/%b/%b/%h required 0/0/0/0000",
                     eng_busy, eng_done, eng_aborted, eng_count);
        end
        checks++;
        if ({tx_wready, rx_rvalid, rx_rdata, tx_level, rx_level} !== {1'b1, 1'b0, 8'h0, 10'h0}) begin
            failures++;
            $display("FAIL reset_fifo got wready=%b rvalid=%b rdata=%h levels=%0d/%0d required 1/0/00/0/0",
                     tx_wready, rx_rvalid, rx_rdata, tx_level, rx_level);
        end
        checks++;
        if ({bus.m_valid, bus.m_write, bus.m_addr, bus.m_wdata, bus.m_wstrb} !== 70'd0) begin
            failures++;
            $display("FAIL reset_bus got v=%b w=%b a=%h d=%h s=%h required all zero",
                     bus.m_valid, bus.m_write, bus.m_addr, bus.m_wdata, bus.m_wstrb);
        end
    endtask

    task automatic test_loopback();
        int wb = wr_log.size(), rb = rx_log.size(), db = done_cnt;
        bit ok;
        push_tx(8'hA5); push_tx(8'h3C); push_tx(8'h0F);
        plan_burst(3, 0, 0);
        start(3, 0, 0);
        repeat (4) @(posedge clk);
        start(7, 1, 1);  // busy: must be ignored
        wait_done(2000, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL loopback_done got timeout required eng_done"); end
        @(posedge clk); #1;
        checks++;
        if (eng_count !== 16'd3 || done_cnt - db !== 1) begin
            failures++;
            $display("FAIL loopback_count got count=%0d pulses=%0d required 3/1", eng_count, done_cnt - db);
        end
        checks++;
        if (wr_log.size() - wb !== 3) begin
            failures++;
            $display("FAIL loopback_nwr got %0d required 3", wr_log.size() - wb);
        end
        for (int i = 0; i < 3 && wb + i < wr_log.size(); i++) begin
            checks++;
            if (wr_log[wb+i] !== exp_wr[i]) begin
                failures++;
                $display("FAIL loopback_wr[%0d] got %h required %h", i, wr_log[wb+i], exp_wr[i]);
            end
        end
        pop_rx(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rb + i >= rx_log.size() || rx_log[rb+i] !== exp_rx[i]) begin
                failures++;
                $display("FAIL loopback_rx[%0d] got %h required %h", i,
                         (rb + i < rx_log.size()) ? rx_log[rb+i] : 8'hxx, exp_rx[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int n = $urandom_range(1, 16 - tx_model.size());
            int len = $urandom_range(1, n + tx_model.size());
            bit discard = 1'($urandom_range(0, 1));
            int wb = wr_log.size(), rb = rx_log.size();
            bit ok;
            wr_hold = $urandom_range(0, 3);
            xfer_cycles = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) push_tx(8'($urandom));
            plan_burst(len, 0, discard);
            start(16'(len), 0, discard);
            wait_done(3000, ok);
            @(posedge clk); #1;
            checks++;
            if (!ok || eng_count !== 16'(len)) begin
                failures++;
                $display("FAIL rand%0d_count got done=%b count=%0d required 1/%0d", it, ok, eng_count, len);
            end
            checks++;
            if (tx_level !== 5'(tx_model.size()) || rx_level !== 5'(exp_rx.size())) begin
                failures++;
                $display("FAIL rand%0d_levels got %0d/%0d required %0d/%0d", it, tx_level, rx_level,
                         tx_model.size(), exp_rx.size());
            end
            for (int i = 0; i < len; i++) begin
                checks++;
                if (wb + i >= wr_log.size() || wr_log[wb+i] !== exp_wr[i]) begin
                    failures++;
                    $display("FAIL rand%0d_wr[%0d] required %h", it, i, exp_wr[i]);
                end
            end
            pop_rx(exp_rx.size());
            for (int i = 0; i < exp_rx.size(); i++) begin
                checks++;
                if (rb + i >= rx_log.size() || rx_log[rb+i] !== exp_rx[i]) begin
                    failures++;
                    $display("FAIL rand%0d_rx[%0d] required %h", it, i, exp_rx[i]);
                end
            end
        end
        wr_hold = 0;
    endtask

    task automatic test_fill_512();
        int wb, rb, bad_wr = 0, bad_rx = 0;
        bit ok;
        xfer_cycles = 2;
        if (tx_model.size() == 0) push_tx(8'h5E);
        wb = wr_log.size(); rb = rx_log.size();
        rx_rready = 1'b1;
        start(16'd512, 1, 0);
        wait_done(30000, ok);
        repeat (3) @(posedge clk);
        #1 rx_rready = 1'b0;
        for (int i = wb; i < wr_log.size(); i++) if (wr_log[i] !== 32'h0000_00FF) bad_wr++;
        for (int i = rb; i < rx_log.size(); i++) if (rx_log[i] !== 8'h00) bad_rx++;
        checks++;
        if (!ok || eng_count !== 16'd512 || wr_log.size() - wb !== 512 || bad_wr !== 0) begin
            failures++;
            $display("FAIL fill512_wr got done=%b count=%0d writes=%0d bad=%0d required 1/512/512/0",
                     ok, eng_count, wr_log.size() - wb, bad_wr);
        end
        checks++;
        if (rx_log.size() - rb !== 512 || bad_rx !== 0) begin
            failures++;
            $display("FAIL fill512_rx got bytes=%0d bad=%0d required 512/0", rx_log.size() - rb, bad_rx);
        end
        checks++;
        if (tx_level !== 5'(tx_model.size())) begin
            failures++;
            $display("FAIL fill512_tx got %0d required %0d", tx_level, tx_model.size());
        end
    endtask

    task automatic test_rx_stall();
        int wb = wr_log.size(), rb = rx_log.size(), n = 0;
        bit ok;
        start(16'd20, 1, 0);
        while (wr_log.size() - wb < 16 && n < 3000) begin @(negedge clk); n++; end
        repeat (200) @(negedge clk);
        checks++;
        if (wr_log.size() - wb !== 16 || rx_level !== 5'd16 || eng_busy !== 1'b1) begin
            failures++;
            $display("FAIL stall_full got writes=%0d rx_level=%0d busy=%b required 16/16/1",
                     wr_log.size() - wb, rx_level, eng_busy);
        end
        pop_rx(4);
        wait_done(2000, ok);
        @(posedge clk); #1;
        checks++;
        if (!ok || wr_log.size() - wb !== 20 || rx_level !== 5'd16 || eng_count !== 16'd20) begin
            failures++;
            $display("FAIL stall_resume got done=%b writes=%0d rx_level=%0d count=%0d required 1/20/16/20",
                     ok, wr_log.size() - wb, rx_level, eng_count);
        end
        pop_rx(16);
        checks++;
        if (rx_log.size() - rb !== 20 || rx_level !== 5'd0) begin
            failures++;
            $display("FAIL stall_drain got %0d level=%0d required 20/0", rx_log.size() - rb, rx_level);
        end
    endtask

    task automatic test_wr_stall();
        int wb = wr_log.size();
        bit ok;
        wr_hold = 50;
        start(16'd2, 1, 1);
        wait_done(3000, ok);
        @(posedge clk); #1;
        wr_hold = 0;
        checks++;
        if (!ok || wr_log.size() - wb !== 2 || max_run <= 50) begin
            failures++;
            $display("FAIL wrstall got done=%b writes=%0d max_valid_run=%0d required 1/2/>50",
                     ok, wr_log.size() - wb, max_run);
        end
        checks++;
        if (hold_viol !== 0 || gap_viol !== 0 || bad_req !== 0 || rx_level !== 5'd0) begin
            failures++;
            $display("FAIL wrstall_proto got hold=%0d gap=%0d badreq=%0d rx_level=%0d required 0/0/0/0",
                     hold_viol, gap_viol, bad_req, rx_level);
        end
    endtask

    task automatic test_abort();
        int wb = wr_log.size(), db = done_cnt, n = 0;
        bit ok;
        xfer_cycles = 4;
        start(16'd10, 1, 1);
        while (wr_log.size() - wb < 3 && n < 2000) begin @(negedge clk); n++; end
        while (!(bus.m_valid && !bus.m_write && bus.m_addr == StatusAddr) && n < 2000) begin
            @(negedge clk); n++;
        end
        @(posedge clk); #1 cmd_abort = 1'b1;
        @(posedge clk); #1 cmd_abort = 1'b0;
        wait_done(2000, ok);
        @(posedge clk); #1;
        checks++;
        if (!ok || eng_count !== 16'd3 || eng_aborted !== 1'b1 || eng_busy !== 1'b0) begin
            failures++;
            $display("FAIL abort got done=%b count=%0d aborted=%b busy=%b required 1/3/1/0",
                     ok, eng_count, eng_aborted, eng_busy);
        end
        checks++;
        if (wr_log.size() - wb !== 3 || done_cnt - db !== 1) begin
            failures++;
            $display("FAIL abort_traffic got writes=%0d pulses=%0d required 3/1",
                     wr_log.size() - wb, done_cnt - db);
        end
        @(posedge clk); #1 cmd_abort = 1'b1;  // idle: ignored
        @(posedge clk); #1 cmd_abort = 1'b0;
        start(16'd1, 1, 1);
        checks++;
        if (eng_aborted !== 1'b0 || eng_busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_clear got aborted=%b busy=%b required 0/1", eng_aborted, eng_busy);
        end
        wait_done(2000, ok);
        @(posedge clk); #1;
        checks++;
        if (!ok || eng_aborted !== 1'b0 || eng_count !== 16'd1) begin
            failures++;
            $display("FAIL abort_next got done=%b aborted=%b count=%0d required 1/0/1", ok, eng_aborted, eng_count);
        end
    endtask

    task automatic test_reset_mid();
        int wb, db, ab, n = 0;
        for (int i = 0; i < 5; i++) push_tx(8'($urandom));
        wb = wr_log.size();
        start(16'd5, 0, 0);
        while (wr_log.size() - wb < 2 && n < 2000) begin @(negedge clk); n++; end
        while (!(bus.m_valid && !bus.m_write && bus.m_addr == StatusAddr) && n < 2000) begin
            @(negedge clk); n++;
        end
        db = done_cnt;
        reset = 1'b1;
        #1;
        checks++;
        if ({eng_busy, eng_done, eng_aborted, eng_count} !== 19'd0) begin
            failures++;
            $display("FAIL rstmid_eng got %b/%b/%b/%h required 0/0/0/0000",
                     eng_busy, eng_done, eng_aborted, eng_count);
        end
        checks++;
        if ({tx_wready, rx_rvalid, rx_rdata, tx_level, rx_level} !== {1'b1, 1'b0, 8'h0, 10'h0}) begin
            failures++;
            $display("FAIL rstmid_fifo got wready=%b rvalid=%b levels=%0d/%0d required 1/0/0/0",
                     tx_wready, rx_rvalid, tx_level, rx_level);
        end
        checks++;
        if ({bus.m_valid, bus.m_write, bus.m_addr, bus.m_wdata, bus.m_wstrb} !== 70'd0) begin
            failures++;
            $display("FAIL rstmid_bus got v=%b a=%h required 0/0", bus.m_valid, bus.m_addr);
        end
        tx_model.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        ab = ack_cnt;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (done_cnt !== db || ack_cnt !== ab || eng_busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_quiet got pulses=%0d acks=%0d busy=%b required 0/0/0",
                     done_cnt - db, ack_cnt - ab, eng_busy);
        end
    endtask

    task automatic test_len0();
        int ab = ack_cnt, db = done_cnt;
        start(16'd0, 0, 0);
        checks++;
        if (eng_done !== 1'b1 || eng_busy !== 1'b0) begin
            failures++;
            $display("FAIL len0_done got done=%b busy=%b required 1/0", eng_done, eng_busy);
        end
        @(posedge clk); #1;
        checks++;
        if (eng_done !== 1'b0) begin
            failures++;
            $display("FAIL len0_pulse got %b required 0", eng_done);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (ack_cnt !== ab || done_cnt - db !== 1 || eng_count !== 16'd0 || bus.m_valid !== 1'b0) begin
            failures++;
            $display("FAIL len0_quiet got acks=%0d pulses=%0d count=%0d required 0/1/0",
                     ack_cnt - ab, done_cnt - db, eng_count);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_random();
        test_fill_512();
        test_rx_stall();
        test_wr_stall();
        test_abort();
        test_reset_mid();
        test_len0();
        checks++;
        if (hold_viol !== 0 || gap_viol !== 0 || bad_req !== 0) begin
            failures++;
            $display("FAIL protocol got hold=%0d gap=%0d badreq=%0d required 0/0/0",
                     hold_viol, gap_viol, bad_req);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
